// File: rtl/cursor_pkg.sv
// rtl/cursor_pkg.sv - shared types and direction indices for the cursor button scheduler
package cursor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } dir_state_t;

    localparam int DIR_R = 0;
    localparam int DIR_L = 1;
    localparam int DIR_U = 2;
    localparam int DIR_D = 3;
    localparam int BTN_C = 4;

    // R/L and U/D occupy adjacent even/odd slots, so flipping bit 0 gives the opposite.
    function automatic int opposite_dir(input int d);
        return d ^ 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus stable-count debouncer for one button
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // This is the Nth consecutive disagreeing cycle: accept the new level.
                level <= sync2;
                cnt   <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cursor_btn_sched.sv
// rtl/cursor_btn_sched.sv - debounced buttons to single-cycle cursor step strobes with auto-repeat
module cursor_btn_sched
    import cursor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btnR_raw,
    input  logic btnL_raw,
    input  logic btnU_raw,
    input  logic btnD_raw,
    input  logic btnC_raw,
    output logic movR,
    output logic movL,
    output logic movU,
    output logic movD,
    output logic fire
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [4:0] raw_vec;
    logic [4:0] lvl;
    logic [3:0] mov;
    logic       c_prev;

    assign raw_vec = {btnC_raw, btnD_raw, btnU_raw, btnL_raw, btnR_raw};

    for (genvar b = 0; b < 5; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_vec[b]),
            .level(lvl[b])
        );
    end

    for (genvar d = 0; d < 4; d++) begin : g_dir
        localparam int OPP = opposite_dir(d);

        dir_state_t    state;
        dir_state_t    state_nxt;
        logic [RW-1:0] cnt;
        logic [RW-1:0] cnt_nxt;
        logic [RW-1:0] cnt_inc;
        logic          strobe;
        logic          strobe_nxt;
        logic          act;

        // Holding the opposite direction cancels this one outright.
        assign act     = lvl[d] & en & ~lvl[OPP];
        assign cnt_inc = (cnt == '1) ? cnt : cnt + RW'(1);

        always_comb begin
            state_nxt  = state;
            cnt_nxt    = cnt;
            strobe_nxt = 1'b0;
            if (!act) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                case (state)
                    IDLE: begin
                        strobe_nxt = 1'b1;
                        state_nxt  = DELAY;
                        cnt_nxt    = '0;
                    end
                    DELAY: begin
                        if (cnt == RW'(REPEAT_DELAY - 1)) begin
                            strobe_nxt = 1'b1;
                            state_nxt  = REPEAT;
                            cnt_nxt    = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                    REPEAT: begin
                        if (cnt == RW'(REPEAT_PERIOD - 1)) begin
                            strobe_nxt = 1'b1;
                            cnt_nxt    = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= IDLE;
                cnt    <= '0;
                strobe <= 1'b0;
            end else begin
                state  <= state_nxt;
                cnt    <= cnt_nxt;
                strobe <= strobe_nxt;
            end
        end

        assign mov[d] = strobe;
    end

    // c_prev tracks the level regardless of en, so a C held across re-enable sees no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_prev <= 1'b0;
            fire   <= 1'b0;
        end else begin
            c_prev <= lvl[BTN_C];
            fire   <= en & lvl[BTN_C] & ~c_prev;
        end
    end

    assign movR = mov[DIR_R];
    assign movL = mov[DIR_L];
    assign movU = mov[DIR_U];
    assign movD = mov[DIR_D];

endmodule

// File: tb/tb_cursor_btn_sched.sv
// tb/tb_cursor_btn_sched.sv - randomized self-checking bench for cursor_btn_sched
module tb_cursor_btn_sched;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;

    logic clk = 1'b0;
    logic rst, en;
    logic btn_r, btn_l, btn_u, btn_d, btn_c;
    logic mov_r, mov_l, mov_u, mov_d, fire;
    logic [4:0] outs;

    always #5 clk = ~clk;

    cursor_btn_sched #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .btnR_raw(btn_r),
        .btnL_raw(btn_l),
        .btnU_raw(btn_u),
        .btnD_raw(btn_d),
        .btnC_raw(btn_c),
        .movR    (mov_r),
        .movL    (mov_l),
        .movU    (mov_u),
        .movD    (mov_d),
        .fire    (fire)
    );

    assign outs = {fire, mov_d, mov_u, mov_l, mov_r};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a button's level flips once the last DB synchronised samples all disagree
    // with it; a direction strobes at 0, RD, RD+RP, RD+2RP... cycles into an unbroken active run.
    logic [63:0] hist [5];
    logic [4:0]  lvl;
    logic        c_prev;
    int          run [4];
    logic [4:0]  exp_out;

    logic        st_rst, st_en;
    logic [4:0]  st_btn;

    task automatic model_reset();
        for (int b = 0; b < 5; b++) hist[b] = '0;
        for (int d = 0; d < 4; d++) run[d] = 0;
        lvl     = '0;
        c_prev  = 1'b0;
        exp_out = '0;
    endtask

    task automatic model_step(input logic [4:0] b_in, input logic en_in);
        logic [4:0] nx;
        logic       all_diff;
        int         k;
        nx = '0;
        for (int d = 0; d < 4; d++) begin
            if (lvl[d] && en_in && !lvl[d ^ 1]) begin
                k     = run[d];
                nx[d] = (k == 0) || (k == RD) || (k > RD && ((k - RD) % RP) == 0);
                if (run[d] < 1_000_000) run[d] = run[d] + 1;
            end else begin
                run[d] = 0;
            end
        end
        nx[4]  = en_in && lvl[4] && !c_prev;
        c_prev = lvl[4];
        for (int b = 0; b < 5; b++) begin
            hist[b]  = {hist[b][62:0], b_in[b]};
            all_diff = 1'b1;
            for (int i = 2; i <= DB + 1; i++)
                if (hist[b][i] == lvl[b]) all_diff = 1'b0;
            if (all_diff) lvl[b] = ~lvl[b];
        end
        exp_out = nx;
    endtask

    task automatic tick();
        @(negedge clk);
        if (st_rst && !rst) begin
            rst = 1'b1;
            #1;
            chk("rst_async", {27'd0, outs}, 32'd0);
            model_reset();
        end else begin
            rst = st_rst;
        end
        en = st_en;
        {btn_c, btn_d, btn_u, btn_l, btn_r} = st_btn;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(st_btn, st_en);
        #1;
        chk("outs", {27'd0, outs}, {27'd0, exp_out});
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int lat;
    int hold_cnt [5];
    int en_cnt;

    initial begin
        rst = 1'b1; en = 1'b0;
        {btn_c, btn_d, btn_u, btn_l, btn_r} = '0;
        model_reset();
        st_rst = 1'b1; st_en = 1'b1; st_btn = '0;

        // Reset held while buttons toggle.
        for (int i = 0; i < 2; i++) begin
            st_btn = 5'($urandom);
            tick();
        end
        chk("reset_outs", {27'd0, outs}, 32'd0);
        st_rst = 1'b0; st_btn = '0;
        run_cycles(10);

        // Short glitch on R.
        st_btn = 5'b00001; run_cycles(3);
        st_btn = '0;       run_cycles(15);

        // First-strobe latency from raw edge.
        st_btn = 5'b00001;
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            lat++;
            if (mov_r) break;
        end
        chk("latency_R", lat, 32'd7);
        run_cycles(45);
        st_btn = '0; run_cycles(20);

        // Opposing pair, then release of one side.
        st_btn = 5'b00001; run_cycles(30);
        st_btn = 5'b00011; run_cycles(30);
        st_btn = 5'b00010; run_cycles(40);
        st_btn = '0;       run_cycles(15);

        // Diagonal plus held fire.
        st_btn = 5'b10101; run_cycles(100);
        st_btn = '0;       run_cycles(15);

        // en drop mid-REPEAT, then reset mid-DELAY.
        st_btn = 5'b01000; run_cycles(40);
        st_en = 1'b0;      run_cycles(10);
        st_en = 1'b1;      run_cycles(30);
        st_btn = '0;       run_cycles(15);
        st_btn = 5'b01000; run_cycles(14);
        st_rst = 1'b1;     tick();
        st_rst = 1'b0;     run_cycles(20);
        st_btn = '0;       run_cycles(15);

        // Randomized long-hold/glitch mix with occasional en drops and resets.
        for (int b = 0; b < 5; b++) hold_cnt[b] = 0;
        en_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 5; b++) begin
                if (hold_cnt[b] == 0) begin
                    st_btn[b]   = 1'($urandom_range(0, 1));
                    hold_cnt[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                              : int'($urandom_range(10, 80));
                end else begin
                    hold_cnt[b]--;
                end
            end
            if (en_cnt == 0) begin
                st_en  = ($urandom_range(0, 9) != 0);
                en_cnt = st_en ? int'($urandom_range(20, 200)) : int'($urandom_range(1, 12));
            end else begin
                en_cnt--;
            end
            st_rst = ($urandom_range(0, 799) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
